// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, sign-extender control encodings
// and opcode match constants used by fetch, sign extender and control unit.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        EXT_I  = 2'b00,
        EXT_D  = 2'b01,
        EXT_B  = 2'b10,
        EXT_CB = 2'b11
    } ext_ctrl_e;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    // Word offset is shifted in 64 bits, so its top two bits fall off; sum wraps.
    function automatic logic [63:0] next_pc(input logic [63:0] pc,
                                            input logic [63:0] imm,
                                            input logic        take);
        logic [63:0] r_sum;
        if (take) begin
            r_sum = pc + (imm << 2);
        end else begin
            r_sum = pc + 64'd4;
        end
        return r_sum;
    endfunction

endpackage

// File: rtl/instr_fetch_imm_ctrl_decode.sv
// Combinational sign-extender control decode from the instruction opcode field
// (Instruction[31:21]).
module imm_ctrl_decode
    import instr_fetch_pkg::*;
(
    input  logic [10:0] i_opcode,
    output logic [1:0]  o_ext_ctrl
);

    ext_ctrl_e w_ext;

    // Prefix match on progressively shorter opcode fields.
    always_comb begin
        w_ext = EXT_I;
        if ((i_opcode == OPC_LDUR) || (i_opcode == OPC_STUR)) begin
            w_ext = EXT_D;
        end else if (i_opcode[10:5] == OPC_B) begin
            w_ext = EXT_B;
        end else if (i_opcode[10:3] == OPC_CBZ) begin
            w_ext = EXT_CB;
        end else begin
            w_ext = EXT_I;
        end
    end

    assign o_ext_ctrl = w_ext;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/FETCH/HOLD sequencer, PC register and
// instruction register, with branch-target selection on consumption.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [63:0] StartPC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        MemReq,
    output logic [63:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    input  logic [63:0] BusImm,
    output logic [63:0] CurrentPC,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [25:0] Imm26,
    output logic [1:0]  ExtCtrl
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [63:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic         w_take;
    logic         w_req;

    assign w_take = Uncondbranch | (Branch & Zero);

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and memory request decode.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (MemAck) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!Stall) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC, instruction register and valid flag.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_pc    <= StartPC;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (MemAck) begin
                        r_instr <= MemData;
                        r_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Branch inputs only matter in the cycle the word is consumed.
                    if (!Stall) begin
                        r_pc    <= next_pc(r_pc, BusImm, w_take);
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= r_valid;
                end
            endcase
        end
    end

    imm_ctrl_decode u_imm_ctrl_decode (
        .i_opcode   (r_instr[31:21]),
        .o_ext_ctrl (ExtCtrl)
    );

    assign MemReq      = w_req;
    assign MemAddr     = r_pc;
    assign CurrentPC   = r_pc;
    assign Instruction = r_instr;
    assign InstrValid  = r_valid;
    assign Imm26       = r_instr[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, fetch handshake,
// branch target selection, stall hold, opcode decode and PC wrap-around.
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemAck;
    logic [31:0] MemData;
    logic        Stall;
    logic        Branch;
    logic        Uncondbranch;
    logic        Zero;
    logic [63:0] BusImm;

    logic        MemReq,    w2_MemReq;
    logic [63:0] MemAddr,   w2_MemAddr;
    logic [63:0] CurrentPC, w2_CurrentPC;
    logic [31:0] Instruction, w2_Instruction;
    logic        InstrValid, w2_InstrValid;
    logic [25:0] Imm26,     w2_Imm26;
    logic [1:0]  ExtCtrl,   w2_ExtCtrl;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch dut (
        .CLK(CLK), .Reset(Reset), .MemReq(MemReq), .MemAddr(MemAddr),
        .MemAck(MemAck), .MemData(MemData), .Stall(Stall), .Branch(Branch),
        .Uncondbranch(Uncondbranch), .Zero(Zero), .BusImm(BusImm),
        .CurrentPC(CurrentPC), .Instruction(Instruction), .InstrValid(InstrValid),
        .Imm26(Imm26), .ExtCtrl(ExtCtrl)
    );

    instr_fetch #(.StartPC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .CLK(CLK), .Reset(Reset), .MemReq(w2_MemReq), .MemAddr(w2_MemAddr),
        .MemAck(MemAck), .MemData(MemData), .Stall(Stall), .Branch(Branch),
        .Uncondbranch(Uncondbranch), .Zero(Zero), .BusImm(BusImm),
        .CurrentPC(w2_CurrentPC), .Instruction(w2_Instruction), .InstrValid(w2_InstrValid),
        .Imm26(w2_Imm26), .ExtCtrl(w2_ExtCtrl)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called while in FETCH: one acked cycle lands the word in HOLD.
    task automatic fetch_word(input logic [31:0] data);
        MemAck  = 1'b1;
        MemData = data;
        Stall   = 1'b1;
        @(posedge CLK); #1;
        MemAck  = 1'b0;
        MemData = 32'hDEAD_BEEF;
    endtask

    task automatic consume(input logic br, input logic ub, input logic z, input logic [63:0] imm);
        Stall        = 1'b0;
        Branch       = br;
        Uncondbranch = ub;
        Zero         = z;
        BusImm       = imm;
        @(posedge CLK); #1;
        Stall        = 1'b1;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        BusImm       = 64'h0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        Reset = 1'b1; MemAck = 1'b0; MemData = 32'h0; Stall = 1'b1;
        Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0; BusImm = 64'h0;
        #2;
        check_eq("rst_memreq",  {63'h0, MemReq}, 64'h0);
        check_eq("rst_pc",      CurrentPC, 64'h0);
        check_eq("rst_valid",   {63'h0, InstrValid}, 64'h0);
        check_eq("rst_instr",   {32'h0, Instruction}, 64'h0);
        check_eq("rst_imm26",   {38'h0, Imm26}, 64'h0);
        check_eq("rst_ext",     {62'h0, ExtCtrl}, 64'h0);
        check_eq("rst_pc_wrap", w2_CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_held_memreq", {63'h0, MemReq}, 64'h0);

        // Release: first edge enters FETCH at StartPC
        @(negedge CLK); Reset = 1'b0;
        @(posedge CLK); #1;
        check_eq("fetch_memreq", {63'h0, MemReq}, 64'h1);
        check_eq("fetch_addr",   MemAddr, 64'h0);
        check_eq("fetch_valid",  {63'h0, InstrValid}, 64'h0);
        @(posedge CLK); #1;
        check_eq("noack_memreq", {63'h0, MemReq}, 64'h1);
        check_eq("noack_valid",  {63'h0, InstrValid}, 64'h0);

        fetch_word(32'h9100_0421);
        check_eq("addi_valid",  {63'h0, InstrValid}, 64'h1);
        check_eq("addi_instr",  {32'h0, Instruction}, 64'h9100_0421);
        check_eq("addi_ext",    {62'h0, ExtCtrl}, 64'h0);
        check_eq("hold_memreq", {63'h0, MemReq}, 64'h0);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        check_eq("addi_next",   MemAddr, 64'h4);
        check_eq("next_valid",  {63'h0, InstrValid}, 64'h0);
        check_eq("next_memreq", {63'h0, MemReq}, 64'h1);
        check_eq("wrap_next",   w2_MemAddr, 64'h0);

        // Unconditional branch from PC 0
        do_reset();
        fetch_word(32'h1400_0003);
        check_eq("b_ext",   {62'h0, ExtCtrl}, 64'h2);
        check_eq("b_imm26", {38'h0, Imm26}, 64'h3);
        consume(1'b0, 1'b1, 1'b0, 64'h3);
        check_eq("b_target", MemAddr, 64'hC);

        fetch_word(32'h9100_0421);
        consume(1'b0, 1'b0, 1'b1, 64'h100);
        check_eq("zero_only_seq", MemAddr, 64'h10);

        // CBZ: not taken, then taken backwards twice
        fetch_word(32'hB400_0000);
        check_eq("cbz_ext", {62'h0, ExtCtrl}, 64'h3);
        consume(1'b1, 1'b0, 1'b0, 64'h5);
        check_eq("cbz_nt", MemAddr, 64'h14);
        fetch_word(32'hB400_0000);
        consume(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("cbz_t1", MemAddr, 64'h10);
        fetch_word(32'hB400_0000);
        consume(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("cbz_t2", MemAddr, 64'hC);

        // LDUR held under stall while MemAck and branch inputs wiggle
        fetch_word(32'hF840_0000);
        check_eq("ldur_ext", {62'h0, ExtCtrl}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            MemAck = (i != 1); MemData = 32'h1400_0003;
            Branch = 1'b1; Uncondbranch = 1'b1; Zero = 1'b1; BusImm = 64'h40;
            Stall = 1'b1;
            @(posedge CLK); #1;
            check_eq("stall_instr",  {32'h0, Instruction}, 64'hF840_0000);
            check_eq("stall_ext",    {62'h0, ExtCtrl}, 64'h1);
            check_eq("stall_pc",     CurrentPC, 64'hC);
            check_eq("stall_memreq", {63'h0, MemReq}, 64'h0);
            check_eq("stall_valid",  {63'h0, InstrValid}, 64'h1);
        end
        MemAck = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; Zero = 1'b0; BusImm = 64'h0;
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        check_eq("ldur_next", MemAddr, 64'h10);

        // Decode boundaries
        fetch_word(32'hF800_0000);
        check_eq("stur_ext", {62'h0, ExtCtrl}, 64'h1);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        fetch_word(32'hF860_0000);
        check_eq("nearldur_ext", {62'h0, ExtCtrl}, 64'h0);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        fetch_word(32'hB500_0000);
        check_eq("cbnz_ext", {62'h0, ExtCtrl}, 64'h0);
        consume(1'b0, 1'b0, 1'b0, 64'h0);
        check_eq("seq_1c", MemAddr, 64'h1C);
        fetch_word(32'h17FF_FFFF);
        check_eq("bneg_ext",   {62'h0, ExtCtrl}, 64'h2);
        check_eq("bneg_imm26", {38'h0, Imm26}, 64'h3FF_FFFF);
        consume(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("bneg_target", MemAddr, 64'h18);
        fetch_word(32'h1400_0001);
        consume(1'b0, 1'b1, 1'b0, 64'hC000_0000_0000_0001);
        check_eq("imm_topbits_drop", MemAddr, 64'h1C);

        // Asynchronous reset during FETCH; ack under reset is ignored
        #2 Reset = 1'b1;
        #1;
        check_eq("arst_memreq", {63'h0, MemReq}, 64'h0);
        check_eq("arst_valid",  {63'h0, InstrValid}, 64'h0);
        check_eq("arst_pc",     CurrentPC, 64'h0);
        MemAck = 1'b1; MemData = 32'hF840_0000;
        @(posedge CLK); #1;
        check_eq("arst_ack_valid", {63'h0, InstrValid}, 64'h0);
        check_eq("arst_ack_instr", {32'h0, Instruction}, 64'h0);
        MemAck = 1'b0;
        @(negedge CLK); Reset = 1'b0;
        @(posedge CLK); #1;
        check_eq("rerel_memreq", {63'h0, MemReq}, 64'h1);
        check_eq("rerel_addr",   MemAddr, 64'h0);

        // Asynchronous reset during HOLD
        fetch_word(32'hF840_0000);
        #2 Reset = 1'b1;
        #1;
        check_eq("hrst_valid", {63'h0, InstrValid}, 64'h0);
        check_eq("hrst_ext",   {62'h0, ExtCtrl}, 64'h0);
        check_eq("hrst_imm26", {38'h0, Imm26}, 64'h0);
        @(negedge CLK); Reset = 1'b0;
        @(posedge CLK); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
